// File: rtl/encoder128_7_rr.sv
// encoder128_7_rr
// Registered 128-to-7 encoder with round-robin priority. It returns the index
// of the first set bit in data_in at or after the search pointer, wrapping to
// the lowest set bit if nothing is set at or above the pointer. The result is
// registered, so it appears one cycle after the vector is accepted.
//
// Ports:
//   clk, rst             clock (rising edge), synchronous active-high reset
//   data_in[127:0]       flag vector, bit i set = entry i requesting
//   in_valid / in_ready  input handshake
//   data_out[6:0]        selected index
//   none_out             no bit was set in the captured vector
//   out_valid/out_ready  output handshake
//   ptr_out[6:0]         current search pointer
//
// Parameters:
//   RR_EN     1 = round-robin from pointer, 0 = fixed lowest-index priority
//   PTR_INIT  pointer value loaded on reset (0..127)
module encoder128_7_rr #(
    parameter int RR_EN    = 1,
    parameter int PTR_INIT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] data_in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [6:0]   data_out,
    output logic         none_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [6:0]   ptr_out
);

    localparam logic [6:0] PTR_RST = 7'(PTR_INIT);

    logic [6:0]  ptr;
    logic [6:0]  search_ptr;
    logic [63:0] mask_lo, mask_hi;
    logic [63:0] a_lo, a_hi;       // candidates at or above the pointer
    logic [63:0] srch_lo, srch_hi; // vector each half search actually scans
    logic [5:0]  idx_lo, idx_hi;
    logic [6:0]  sel_idx;
    logic        sel_none;

    // Lowest set bit of a 64-bit half; 0 when the half is empty.
    function automatic logic [5:0] lowest64(input logic [63:0] v);
        logic [5:0] idx;
        idx = '0;
        for (int i = 63; i >= 0; i--) begin
            if (v[i]) idx = 6'(i);
        end
        return idx;
    endfunction

    // Fixed-priority builds search from index 0, which is the same as the
    // round-robin search with a zero pointer.
    assign search_ptr = (RR_EN != 0) ? ptr : 7'd0;

    always_comb begin
        mask_lo  = '0;
        mask_hi  = '0;
        a_lo     = '0;
        a_hi     = '0;
        srch_lo  = '0;
        srch_hi  = '0;
        idx_lo   = '0;
        idx_hi   = '0;
        sel_idx  = '0;
        sel_none = 1'b0;

        // Pointer in the upper half: nothing in the lower half is at/above it,
        // and the upper half is masked from the pointer's low bits.
        if (search_ptr[6]) begin
            mask_lo = '0;
            mask_hi = {64{1'b1}} << search_ptr[5:0];
        end else begin
            mask_lo = {64{1'b1}} << search_ptr[5:0];
            mask_hi = {64{1'b1}};
        end
        a_lo = data_in[63:0]   & mask_lo;
        a_hi = data_in[127:64] & mask_hi;

        // Each half scans its masked candidates if any, else its full bits.
        // The combine order below makes the full-half fallback only win when
        // there are no candidates anywhere (the wrap case).
        srch_lo = (a_lo != '0) ? a_lo : data_in[63:0];
        srch_hi = (a_hi != '0) ? a_hi : data_in[127:64];
        idx_lo  = lowest64(srch_lo);
        idx_hi  = lowest64(srch_hi);

        if (a_lo != '0)                sel_idx = {1'b0, idx_lo};
        else if (a_hi != '0)           sel_idx = {1'b1, idx_hi};
        else if (data_in[63:0] != '0)  sel_idx = {1'b0, idx_lo};
        else if (data_in[127:64] != '0) sel_idx = {1'b1, idx_hi};
        else                           sel_none = 1'b1;
    end

    assign in_ready = !out_valid || out_ready;
    assign ptr_out  = ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            none_out  <= 1'b0;
            ptr       <= PTR_RST;
        end else begin
            // Pointer advances past a delivered, non-empty result. The new
            // vector captured on this same edge already used the old pointer.
            if (RR_EN != 0 && out_valid && out_ready && !none_out)
                ptr <= data_out + 7'd1;

            if (in_ready) begin
                out_valid <= in_valid;
                if (in_valid) begin
                    data_out <= sel_idx;
                    none_out <= sel_none;
                end
            end
        end
    end

endmodule

// File: tb/tb_encoder128_7_rr.sv
module tb_encoder128_7_rr;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] data_in;
    logic         in_valid;
    logic         out_ready;

    logic         in_ready, none_out, out_valid;
    logic [6:0]   data_out, ptr_out;
    logic         in_ready0, none_out0, out_valid0;
    logic [6:0]   data_out0, ptr_out0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    encoder128_7_rr #(.RR_EN(1), .PTR_INIT(0)) dut_rr (
        .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid),
        .in_ready(in_ready), .data_out(data_out), .none_out(none_out),
        .out_valid(out_valid), .out_ready(out_ready), .ptr_out(ptr_out)
    );

    // Fixed-priority build sharing the same stimulus.
    encoder128_7_rr #(.RR_EN(0), .PTR_INIT(5)) dut_fp (
        .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid),
        .in_ready(in_ready0), .data_out(data_out0), .none_out(none_out0),
        .out_valid(out_valid0), .out_ready(out_ready), .ptr_out(ptr_out0)
    );

    typedef struct {
        logic [127:0] vec;
        logic         none;
        int           idx_rr;   // expected index, round-robin build
        int           ptr_rr;   // expected pointer after delivery
        int           idx_fp;   // expected index, fixed-priority build
    } vec_t;

    vec_t tbl[16];

    function automatic logic [127:0] bits3(input int a, input int b, input int c);
        logic [127:0] v;
        v = '0;
        if (a >= 0) v[a] = 1'b1;
        if (b >= 0) v[b] = 1'b1;
        if (c >= 0) v[c] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{bits3(-1, -1, -1), 1'b1, 0,   0,   0};
        tbl[1]  = '{bits3(5, 70, 127), 1'b0, 5,   6,   5};
        tbl[2]  = '{bits3(5, 70, 127), 1'b0, 70,  71,  5};
        tbl[3]  = '{bits3(5, 70, 127), 1'b0, 127, 0,   5};
        tbl[4]  = '{bits3(99, -1, -1), 1'b0, 99,  100, 99};
        tbl[5]  = '{bits3(3, -1, -1),  1'b0, 3,   4,   3};
        tbl[6]  = '{bits3(99, -1, -1), 1'b0, 99,  100, 99};
        tbl[7]  = '{bits3(100, -1, -1), 1'b0, 100, 101, 100};
        tbl[8]  = '{bits3(0, 100, -1), 1'b0, 0,   1,   0};
        tbl[9]  = '{bits3(1, 64, -1),  1'b0, 1,   2,   1};
        tbl[10] = '{bits3(63, 64, -1), 1'b0, 63,  64,  63};
        tbl[11] = '{bits3(63, 64, -1), 1'b0, 64,  65,  63};
        tbl[12] = '{{128{1'b1}},       1'b0, 65,  66,  0};
        tbl[13] = '{bits3(9, 2, -1),   1'b0, 2,   3,   2};
        tbl[14] = '{bits3(9, 2, -1),   1'b0, 9,   10,  2};
        tbl[15] = '{bits3(-1, -1, -1), 1'b1, 0,   10,  0};

        rst = 1'b1; data_in = '0; in_valid = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("reset out_valid", 32'(out_valid), 0);
        chk("reset data_out", 32'(data_out), 0);
        chk("reset none_out", 32'(none_out), 0);
        chk("reset ptr", 32'(ptr_out), 0);
        chk("reset in_ready", 32'(in_ready), 1);
        chk("reset ptr fp", 32'(ptr_out0), 5);

        // Table: accept one vector, then a bubble cycle for its delivery so
        // the next vector sees the updated pointer.
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            data_in = tbl[i].vec; in_valid = 1'b1;
            tick();
            data_in = '0; in_valid = 1'b0;
            chk($sformatf("t%0d out_valid", i), 32'(out_valid), 1);
            chk($sformatf("t%0d none", i), 32'(none_out), 32'(tbl[i].none));
            chk($sformatf("t%0d data_out", i), 32'(data_out), 32'(tbl[i].idx_rr));
            chk($sformatf("t%0d fp data_out", i), 32'(data_out0), 32'(tbl[i].idx_fp));
            chk($sformatf("t%0d fp none", i), 32'(none_out0), 32'(tbl[i].none));
            tick();
            chk($sformatf("t%0d delivered", i), 32'(out_valid), 0);
            chk($sformatf("t%0d ptr", i), 32'(ptr_out), 32'(tbl[i].ptr_rr));
            chk($sformatf("t%0d fp ptr", i), 32'(ptr_out0), 5);
        end

        // Back-to-back: the vector accepted on a delivery edge uses the old ptr.
        data_in = bits3(20, 50, -1); in_valid = 1'b1; out_ready = 1'b1;
        tick();
        chk("b2b first", 32'(data_out), 20);
        tick();
        chk("b2b second old ptr", 32'(data_out), 20);
        chk("b2b ptr after 1st", 32'(ptr_out), 21);
        tick();
        chk("b2b third new ptr", 32'(data_out), 50);
        in_valid = 1'b0;
        tick();
        chk("b2b drained", 32'(out_valid), 0);
        chk("b2b ptr final", 32'(ptr_out), 51);

        // Backpressure hold: bit 64 result held for 4 cycles.
        data_in = bits3(64, -1, -1); in_valid = 1'b1; out_ready = 1'b0;
        tick();
        chk("bp accept", 32'(data_out), 64);
        data_in = bits3(10, -1, -1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("bp%0d in_ready", k), 32'(in_ready), 0);
            tick();
            chk($sformatf("bp%0d out_valid", k), 32'(out_valid), 1);
            chk($sformatf("bp%0d data_out", k), 32'(data_out), 64);
            chk($sformatf("bp%0d none", k), 32'(none_out), 0);
            chk($sformatf("bp%0d ptr", k), 32'(ptr_out), 51);
        end
        out_ready = 1'b1;
        #1;
        chk("bp release in_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        chk("bp next out_valid", 32'(out_valid), 1);
        chk("bp next data_out wrap", 32'(data_out), 10);
        chk("bp ptr after 64", 32'(ptr_out), 65);
        tick();
        chk("bp ptr after 10", 32'(ptr_out), 11);

        // Reset while a result is held: it must never be delivered.
        data_in = bits3(30, -1, -1); in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("rh held valid", 32'(out_valid), 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rh out_valid", 32'(out_valid), 0);
        chk("rh ptr", 32'(ptr_out), 0);
        chk("rh in_ready", 32'(in_ready), 1);
        chk("rh data_out", 32'(data_out), 0);
        chk("rh fp ptr", 32'(ptr_out0), 5);
        out_ready = 1'b1;
        tick(); tick();
        chk("rh no delivery", 32'(out_valid), 0);
        chk("rh ptr stays", 32'(ptr_out), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
